uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Command-framing controller that sits directly behind uart_rx and drives the jukebox player logic.
- Converts raw received bytes into validated command packets and presents each packet to the player with a valid/ack handshake.
- Packet format: sync byte 0xA5, CMD, LEN (0..MAX_LEN), LEN argument bytes, CKSUM.
- CKSUM is the XOR of CMD, LEN and all argument bytes.
- Enforces an inter-byte timeout and reports checksum, length, timeout and overrun errors.

Parameters:
- CLOCK_RATE, 100000000, i_CLK frequency in Hz.
- TIMEOUT_US, 1000, maximum gap between bytes inside a packet, in microseconds. TIMEOUT_CLKS = (CLOCK_RATE/1000000)*TIMEOUT_US.
- MAX_LEN, 4, maximum argument byte count. Legal range 1..4; o_ARG is always 32 bits wide.

Ports:
- i_CLK  input  1  system clock.
- i_RST_N  input  1  asynchronous active-low reset.
- i_RX_READY  input  1  byte-ready from uart_rx. This is a level: it may stay high for multiple cycles per byte.
- i_RX_DATA  input  8  received byte, stable while i_RX_READY is high.
- o_CMD_VALID  output  1  a validated packet is held on o_CMD/o_LEN/o_ARG.
- i_CMD_ACK  input  1  consumer accepts the packet.
- o_CMD  output  8  command byte.
- o_LEN  output  3  argument byte count.
- o_ARG  output  32  arguments, little-endian; first argument byte goes to [7:0]; unused bytes are 0.
- o_ERR_CKSUM  output  1  one-cycle pulse: checksum mismatch.
- o_ERR_LEN  output  1  one-cycle pulse: LEN > MAX_LEN.
- o_ERR_TIMEOUT  output  1  one-cycle pulse: inter-byte timeout.
- o_ERR_OVERRUN  output  1  one-cycle pulse: byte arrived while a packet was awaiting ack.
- o_BUSY  output  1  high in every state except IDLE.

Behaviour:
- **Reset.** Async assert, clocked release. All outputs reset to 0. State resets to IDLE, counters and the checksum accumulator to 0. ready_d resets to 1, so a READY level already high at reset release is not taken as a byte.
- **Byte strobe.** ready_d <= i_RX_READY each cycle; byte_stb = i_RX_READY & ~ready_d. Exactly one strobe per READY rising edge, regardless of how long READY stays high. Data is sampled on the strobe cycle.
- **IDLE.**
  - On strobe with 0xA5: clear o_ARG and arg index, clear acc, go to CMD.
  - Any other byte is dropped silently.
- **CMD.** On strobe: o_CMD <= byte, acc <= byte, go to LEN.
- **LEN.** On strobe: acc ^= byte, then:
  - byte > MAX_LEN: pulse o_ERR_LEN, go to IDLE.
  - byte == 0: o_LEN <= 0, go to CKSUM.
  - otherwise: o_LEN <= byte[2:0], go to ARG.
- **ARG.** On strobe: o_ARG[8*idx +: 8] <= byte, acc ^= byte, idx++. Go to CKSUM after the o_LEN-th byte.
- **CKSUM.** On strobe:
  - byte == acc: set o_CMD_VALID on the next edge (1 cycle after the strobe) and go to PRESENT.
  - mismatch: pulse o_ERR_CKSUM, go to IDLE, o_CMD_VALID stays 0.
- **PRESENT.**
  - o_CMD_VALID stays high; o_CMD/o_LEN/o_ARG are held stable.
  - On an edge with i_CMD_ACK=1: o_CMD_VALID <= 0, go to IDLE.
  - A strobe in PRESENT pulses o_ERR_OVERRUN and the byte is discarded. This also applies to a strobe in the same cycle as ack; the byte is not parsed as sync.
- **Timeout.**
  - In CMD, LEN, ARG and CKSUM, a 32-bit counter increments each cycle.
  - The counter clears on a strobe and on entering CMD.
  - When the counter reaches TIMEOUT_CLKS-1 without a strobe: pulse o_ERR_TIMEOUT, go to IDLE.
  - A strobe in that same cycle wins (byte accepted, no timeout).
  - No timeout in IDLE or PRESENT.
- **Error pulses.** Each is exactly one cycle. At most one error pulse per cycle.
- **Reset mid-packet.** Reset returns to IDLE immediately and the partial packet is lost. The first packet after reset is parsed normally.

Test Plan:
1. Send A5 10 02 34 12 34, each READY held 3 cycles, gaps of 20 cycles -> o_CMD_VALID rises 1 cycle after the last strobe with o_CMD=0x10, o_LEN=2, o_ARG=0x00001234. Valid holds until ack; drops the cycle after ack.
2. Send 55 A5 20 00 20 (leading junk, zero length) -> 0x55 ignored; o_CMD=0x20, o_LEN=0, o_ARG=0, valid asserted.
3. Send A5 10 02 34 12 35 -> one-cycle o_ERR_CKSUM, o_CMD_VALID stays 0, o_BUSY drops. Then A5 20 00 20 -> packet accepted normally.
4. Send A5 10 05 -> o_ERR_LEN pulse on the LEN strobe, return to IDLE.
5. With TIMEOUT_US=1, send A5 10, then idle 150 cycles -> o_ERR_TIMEOUT exactly once at 100 cycles after the 0x10 strobe; o_BUSY=0 afterwards.
6. Two cases:
   - Hold a valid packet without ack, send 0xA5 -> o_ERR_OVERRUN pulse, packet fields unchanged.
   - Separately, assert i_RST_N=0 after A5 10 -> all outputs 0 immediately; next A5 20 00 20 is accepted.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - framed command parser between uart_rx and the player
module uart_cmd_ctrl #(
    parameter int CLOCK_RATE = 100000000,
    parameter int TIMEOUT_US = 1000,
    parameter int MAX_LEN    = 4
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic        i_RX_READY,
    input  logic [7:0]  i_RX_DATA,
    output logic        o_CMD_VALID,
    input  logic        i_CMD_ACK,
    output logic [7:0]  o_CMD,
    output logic [2:0]  o_LEN,
    output logic [31:0] o_ARG,
    output logic        o_ERR_CKSUM,
    output logic        o_ERR_LEN,
    output logic        o_ERR_TIMEOUT,
    output logic        o_ERR_OVERRUN,
    output logic        o_BUSY
);

    localparam logic [31:0] TIMEOUT_CLKS = 32'((CLOCK_RATE / 1000000) * TIMEOUT_US);
    localparam logic [7:0]  MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_ARG,
        S_CKSUM,
        S_PRESENT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ready_d;
    logic        byte_stb;
    logic [7:0]  acc;
    logic [2:0]  idx;
    logic [31:0] tmo_cnt;
    logic        counting;
    logic        tmo_hit;
    logic        arg_last;

    logic        err_cksum_nxt;
    logic        err_len_nxt;
    logic        err_tmo_nxt;
    logic        err_ovr_nxt;
    logic        valid_set;
    logic        valid_clr;

    // READY is a level from uart_rx; only its rising edge marks a new byte
    assign byte_stb = i_RX_READY & ~ready_d;
    assign counting = (state == S_CMD) | (state == S_LEN) | (state == S_ARG) | (state == S_CKSUM);
    // A byte arriving on the very last count still wins over the timeout
    assign tmo_hit  = counting & ~byte_stb & (tmo_cnt == TIMEOUT_CLKS - 32'd1);
    assign arg_last = ((idx + 3'd1) == o_LEN);
    assign o_BUSY   = (state != S_IDLE);

    // State register
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: packet framing plus timeout abort
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (byte_stb && (i_RX_DATA == SYNC_BYTE)) begin
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (byte_stb) begin
                    state_nxt = S_LEN;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LEN: begin
                if (byte_stb) begin
                    if (i_RX_DATA > MAX_LEN_B) begin
                        state_nxt = S_IDLE;
                    end else if (i_RX_DATA == 8'd0) begin
                        state_nxt = S_CKSUM;
                    end else begin
                        state_nxt = S_ARG;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ARG: begin
                if (byte_stb) begin
                    if (arg_last) begin
                        state_nxt = S_CKSUM;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CKSUM: begin
                if (byte_stb) begin
                    state_nxt = (i_RX_DATA == acc) ? S_PRESENT : S_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PRESENT: begin
                if (i_CMD_ACK) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: error pulses and valid set/clear for this cycle
    always_comb begin
        err_cksum_nxt = 1'b0;
        err_len_nxt   = 1'b0;
        err_tmo_nxt   = tmo_hit;
        err_ovr_nxt   = 1'b0;
        valid_set     = 1'b0;
        valid_clr     = 1'b0;
        case (state)
            S_LEN: begin
                err_len_nxt = byte_stb & (i_RX_DATA > MAX_LEN_B);
            end
            S_CKSUM: begin
                err_cksum_nxt = byte_stb & (i_RX_DATA != acc);
                valid_set     = byte_stb & (i_RX_DATA == acc);
            end
            S_PRESENT: begin
                // A byte here is dropped, even if the ack lands in the same cycle
                err_ovr_nxt = byte_stb;
                valid_clr   = i_CMD_ACK;
            end
            default: ;
        endcase
    end

    // Datapath: byte edge detect, checksum, argument packing, timeout counter, registered outputs
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            ready_d       <= 1'b1;
            acc           <= 8'd0;
            idx           <= 3'd0;
            tmo_cnt       <= 32'd0;
            o_CMD_VALID   <= 1'b0;
            o_CMD         <= 8'd0;
            o_LEN         <= 3'd0;
            o_ARG         <= 32'd0;
            o_ERR_CKSUM   <= 1'b0;
            o_ERR_LEN     <= 1'b0;
            o_ERR_TIMEOUT <= 1'b0;
            o_ERR_OVERRUN <= 1'b0;
        end else begin
            ready_d       <= i_RX_READY;
            o_ERR_CKSUM   <= err_cksum_nxt;
            o_ERR_LEN     <= err_len_nxt;
            o_ERR_TIMEOUT <= err_tmo_nxt;
            o_ERR_OVERRUN <= err_ovr_nxt;
            tmo_cnt       <= (counting && !byte_stb) ? tmo_cnt + 32'd1 : 32'd0;

            if (valid_set) begin
                o_CMD_VALID <= 1'b1;
            end else if (valid_clr) begin
                o_CMD_VALID <= 1'b0;
            end

            if (byte_stb) begin
                case (state)
                    S_IDLE: begin
                        if (i_RX_DATA == SYNC_BYTE) begin
                            o_ARG <= 32'd0;
                            idx   <= 3'd0;
                            acc   <= 8'd0;
                        end
                    end
                    S_CMD: begin
                        o_CMD <= i_RX_DATA;
                        acc   <= i_RX_DATA;
                    end
                    S_LEN: begin
                        acc <= acc ^ i_RX_DATA;
                        if (i_RX_DATA <= MAX_LEN_B) begin
                            o_LEN <= i_RX_DATA[2:0];
                        end
                    end
                    S_ARG: begin
                        o_ARG[{idx[1:0], 3'b000} +: 8] <= i_RX_DATA;
                        acc <= acc ^ i_RX_DATA;
                        idx <= idx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed and randomized checks for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        cmd_ack;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [2:0]  len;
    logic [31:0] arg;
    logic        err_cksum;
    logic        err_len;
    logic        err_tmo;
    logic        err_ovr;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    // Event counters filled by the monitor
    int cyc      = 0;
    int n_cksum  = 0;
    int n_len    = 0;
    int n_tmo    = 0;
    int n_ovr    = 0;
    int n_vrise  = 0;
    int n_multi  = 0;
    int n_long   = 0;
    int tmo_cyc  = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] prev_errs  = 4'd0;

    // Expected event totals from the reference model
    int e_cksum = 0;
    int e_len   = 0;
    int e_tmo   = 0;
    int e_ovr   = 0;
    int e_valid = 0;

    uart_cmd_ctrl #(
        .CLOCK_RATE(100000000),
        .TIMEOUT_US(1),
        .MAX_LEN   (4)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_RX_READY   (rx_ready),
        .i_RX_DATA    (rx_data),
        .o_CMD_VALID  (cmd_valid),
        .i_CMD_ACK    (cmd_ack),
        .o_CMD        (cmd),
        .o_LEN        (len),
        .o_ARG        (arg),
        .o_ERR_CKSUM  (err_cksum),
        .o_ERR_LEN    (err_len),
        .o_ERR_TIMEOUT(err_tmo),
        .o_ERR_OVERRUN(err_ovr),
        .o_BUSY       (busy)
    );

    always #5 clk = ~clk;

    // Monitor: tallies pulses shortly after each rising edge
    always @(posedge clk) begin
        logic [3:0] errs;
        #2;
        cyc++;
        errs = {err_cksum, err_len, err_tmo, err_ovr};
        if (rst_n) begin
            if (err_cksum) n_cksum++;
            if (err_len)   n_len++;
            if (err_tmo) begin
                n_tmo++;
                tmo_cyc = cyc;
            end
            if (err_ovr) n_ovr++;
            if ($countones(errs) > 1) n_multi++;
            if ((errs & prev_errs) != 4'd0) n_long++;
            if (cmd_valid && !prev_valid) n_vrise++;
        end
        prev_errs  = errs;
        prev_valid = cmd_valid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_n_cksum"}, n_cksum, e_cksum);
        check({tag, "_n_len"},   n_len,   e_len);
        check({tag, "_n_tmo"},   n_tmo,   e_tmo);
        check({tag, "_n_ovr"},   n_ovr,   e_ovr);
        check({tag, "_n_valid"}, n_vrise, e_valid);
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_byte(input int hold_rem, input int gap);
        repeat (hold_rem) @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        strobe(b);
        finish_byte(hold - 1, gap);
    endtask

    task automatic do_ack(input string tag);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check({tag, "_valid_after_ack"}, cmd_valid, 1'b0);
    endtask

    initial begin
        int          cs;
        int          kind;
        int          nj;
        int          plen;
        int          k;
        logic [7:0]  b;
        logic [7:0]  ck;
        logic [31:0] exp_arg;
        logic [7:0]  q[$];

        rst_n    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        cmd_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {cmd_valid, cmd, len, arg, err_cksum, err_len, err_tmo, err_ovr, busy},
              48'd0);

        // READY already high with a sync byte when reset releases: not a byte
        rx_ready = 1'b1;
        rx_data  = 8'hA5;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("ready_high_at_release_busy", busy, 1'b0);
        finish_byte(0, 5);

        // Test 1: basic packet, exact valid timing, ack
        send_byte(8'hA5, 3, 20);
        send_byte(8'h10, 3, 20);
        send_byte(8'h02, 3, 20);
        send_byte(8'h34, 3, 20);
        send_byte(8'h12, 3, 20);
        check("t1_valid_before_cksum", cmd_valid, 1'b0);
        strobe(8'h34);
        check("t1_valid_rise", cmd_valid, 1'b1);
        check("t1_cmd", cmd, 8'h10);
        check("t1_len", len, 3'd2);
        check("t1_arg", arg, 32'h0000_1234);
        finish_byte(2, 20);
        check("t1_valid_held", cmd_valid, 1'b1);
        check("t1_busy", busy, 1'b1);
        e_valid++;
        do_ack("t1");
        check("t1_busy_after_ack", busy, 1'b0);

        // Test 2: junk before sync, zero-length packet
        send_byte(8'h55, 3, 20);
        send_byte(8'hA5, 3, 20);
        send_byte(8'h20, 3, 20);
        send_byte(8'h00, 3, 20);
        send_byte(8'h20, 3, 20);
        check("t2_valid", cmd_valid, 1'b1);
        check("t2_cmd", cmd, 8'h20);
        check("t2_len", len, 3'd0);
        check("t2_arg", arg, 32'd0);
        e_valid++;
        do_ack("t2");

        // Test 3: checksum mismatch then a good packet
        send_byte(8'hA5, 3, 20);
        send_byte(8'h10, 3, 20);
        send_byte(8'h02, 3, 20);
        send_byte(8'h34, 3, 20);
        send_byte(8'h12, 3, 20);
        strobe(8'h35);
        check("t3_err_cksum_pulse", err_cksum, 1'b1);
        check("t3_valid", cmd_valid, 1'b0);
        check("t3_busy", busy, 1'b0);
        @(negedge clk);
        check("t3_err_cksum_one_cycle", err_cksum, 1'b0);
        finish_byte(1, 20);
        e_cksum++;
        send_byte(8'hA5, 3, 20);
        send_byte(8'h20, 3, 20);
        send_byte(8'h00, 3, 20);
        send_byte(8'h20, 3, 20);
        check("t3_recover_valid", cmd_valid, 1'b1);
        check("t3_recover_cmd", cmd, 8'h20);
        e_valid++;
        do_ack("t3");

        // Test 4: length too large
        send_byte(8'hA5, 3, 20);
        send_byte(8'h10, 3, 20);
        strobe(8'h05);
        check("t4_err_len_pulse", err_len, 1'b1);
        check("t4_busy", busy, 1'b0);
        @(negedge clk);
        check("t4_err_len_one_cycle", err_len, 1'b0);
        finish_byte(1, 20);
        e_len++;

        // Test 5: timeout 100 edges after the last strobe
        send_byte(8'hA5, 3, 20);
        strobe(8'h10);
        cs = cyc;
        finish_byte(2, 0);
        repeat (150) @(negedge clk);
        e_tmo++;
        check("t5_tmo_count", n_tmo, e_tmo);
        check("t5_tmo_delay", tmo_cyc - cs, 100);
        check("t5_busy", busy, 1'b0);

        // Byte landing exactly on the last count beats the timeout
        send_byte(8'hA5, 1, 99);
        send_byte(8'h10, 1, 99);
        send_byte(8'h00, 1, 99);
        send_byte(8'h10, 1, 5);
        check("edge_tmo_valid", cmd_valid, 1'b1);
        check("edge_tmo_count", n_tmo, e_tmo);
        e_valid++;
        do_ack("edge_tmo");

        // Test 6a: overrun while presenting
        send_byte(8'hA5, 2, 10);
        send_byte(8'h30, 2, 10);
        send_byte(8'h01, 2, 10);
        send_byte(8'h7E, 2, 10);
        send_byte(8'h4F, 2, 10);
        e_valid++;
        strobe(8'hA5);
        check("t6_err_ovr_pulse", err_ovr, 1'b1);
        check("t6_valid_kept", cmd_valid, 1'b1);
        check("t6_fields_kept", {cmd, len, arg}, {8'h30, 3'd1, 32'h0000_007E});
        finish_byte(2, 10);
        e_ovr++;
        do_ack("t6");

        // Overrun in the same cycle as ack: byte is not taken as sync
        send_byte(8'hA5, 2, 10);
        send_byte(8'h20, 2, 10);
        send_byte(8'h00, 2, 10);
        send_byte(8'h20, 2, 10);
        e_valid++;
        cmd_ack  = 1'b1;
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check("t6_ack_ovr_pulse", err_ovr, 1'b1);
        check("t6_ack_ovr_valid", cmd_valid, 1'b0);
        finish_byte(2, 10);
        e_ovr++;
        send_byte(8'h20, 2, 10);
        send_byte(8'h00, 2, 10);
        send_byte(8'h20, 2, 10);
        check("t6_ack_ovr_not_synced", {busy, cmd_valid}, 2'b00);

        // Test 6b: reset mid-packet
        send_byte(8'hA5, 2, 10);
        send_byte(8'h10, 2, 5);
        rst_n = 1'b0;
        #1;
        check("t6b_reset_outputs",
              {cmd_valid, cmd, len, arg, err_cksum, err_len, err_tmo, err_ovr, busy},
              48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'hA5, 2, 10);
        send_byte(8'h20, 2, 10);
        send_byte(8'h00, 2, 10);
        send_byte(8'h20, 2, 10);
        check("t6b_after_reset_valid", cmd_valid, 1'b1);
        check("t6b_after_reset_cmd", cmd, 8'h20);
        e_valid++;
        do_ack("t6b");
        check_counts("directed");

        // Randomized packets against the reference model
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 9);
            nj   = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                do b = 8'($urandom); while (b == 8'hA5);
                send_byte(b, $urandom_range(1, 4), $urandom_range(1, 30));
            end
            q.delete();
            q.push_back(8'($urandom));
            plen = (kind == 7) ? $urandom_range(5, 255) : $urandom_range(0, 4);
            q.push_back(8'(plen));
            exp_arg = 32'd0;
            if (kind != 7) begin
                for (int i = 0; i < plen; i++) begin
                    q.push_back(8'($urandom));
                    exp_arg = exp_arg | (32'(q[2 + i]) << (8 * i));
                end
            end
            ck = 8'd0;
            foreach (q[i]) ck = ck ^ q[i];
            if (kind == 6) ck = ck ^ 8'($urandom_range(1, 255));
            if (kind != 7) q.push_back(ck);

            send_byte(8'hA5, $urandom_range(1, 4), $urandom_range(1, 30));
            if (kind == 8) begin
                k = $urandom_range(0, q.size() - 1);
                for (int i = 0; i < k; i++) send_byte(q[i], $urandom_range(1, 4), $urandom_range(1, 30));
                repeat (120) @(negedge clk);
                e_tmo++;
            end else begin
                foreach (q[i]) send_byte(q[i], $urandom_range(1, 4), $urandom_range(1, 30));
                if (kind == 6) begin
                    e_cksum++;
                end else if (kind == 7) begin
                    e_len++;
                end else begin
                    e_valid++;
                    check("rnd_valid", cmd_valid, 1'b1);
                    check("rnd_fields", {cmd, len, arg}, {q[0], 3'(plen), exp_arg});
                    if (kind == 9) begin
                        send_byte(8'($urandom), $urandom_range(1, 4), $urandom_range(1, 10));
                        e_ovr++;
                        check("rnd_ovr_fields", {cmd_valid, cmd, len, arg}, {1'b1, q[0], 3'(plen), exp_arg});
                    end
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    do_ack("rnd");
                end
            end
            repeat (3) @(negedge clk);
            check("rnd_busy_idle", busy, 1'b0);
            check_counts("rnd");
        end

        check("one_error_per_cycle", n_multi, 0);
        check("error_pulse_width", n_long, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
